// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Counter width that can hold 0..t; a disabled watchdog still needs one bit.
  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog for a granted strobe: expire is high combinationally on the last
// cycle a strobe may wait without ack.
module wb_timeout_counter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      always_comb begin
        count_d = count_q;
        if (clr) begin
          count_d = '0;
        end else if (inc) begin
          count_d = count_q + CW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // A same-cycle ack raises clr, so it always beats expiry.
      assign expire = inc && !clr && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Round-robin 2:1 Wishbone-classic arbiter; the grant is held for the owner's
// whole cyc and a watchdog turns a never-acked strobe into a one-cycle err.
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_owner_q, last_owner_d;

  logic                  req0, req1;
  logic                  owner_cyc, owner_stb, owner_we;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic [DATA_WIDTH-1:0] owner_wdata;
  logic                  wd_clr, wd_inc, wd_expire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign owner_cyc   = (owner_q == OWNER_M1) ? m1_cyc_i  : m0_cyc_i;
  assign owner_stb   = (owner_q == OWNER_M1) ? m1_stb_i  : m0_stb_i;
  assign owner_we    = (owner_q == OWNER_M1) ? m1_we_i   : m0_we_i;
  assign owner_addr  = (owner_q == OWNER_M1) ? m1_addr_i : m0_addr_i;
  assign owner_wdata = (owner_q == OWNER_M1) ? m1_data_i : m0_data_i;

  assign wd_clr = (state_q != GNT) | s_ack_i | ~owner_stb;
  assign wd_inc = (state_q == GNT) & owner_stb & ~s_ack_i;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  // last_owner resets to m1 so that m0 wins the first tie.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      last_owner_q <= OWNER_M1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = GNT;
          owner_d = ~last_owner_q;
        end else if (req0) begin
          state_d = GNT;
          owner_d = OWNER_M0;
        end else if (req1) begin
          state_d = GNT;
          owner_d = OWNER_M1;
        end
      end
      GNT: begin
        // Dropping cyc is a clean release even if the watchdog fires too.
        if (!owner_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (wd_expire) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      GNT: begin
        s_cyc_o  = owner_cyc;
        s_stb_o  = owner_stb;
        s_we_o   = owner_we;
        s_addr_o = owner_addr;
        s_data_o = owner_wdata;
        m0_ack_o = (owner_q == OWNER_M0) & s_ack_i;
        m1_ack_o = (owner_q == OWNER_M1) & s_ack_i;
      end
      ERR: begin
        m0_err_o = (owner_q == OWNER_M0);
        m1_err_o = (owner_q == OWNER_M1);
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only ack is qualified by ownership.
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule
